// File: rtl/hc595_chain_driver.sv
// Serial driver for a daisy-chain of 74HC595s: divided shift clock, selectable bit
// order, one-deep pending frame buffer, optional auto-refresh and managed /OE.
module hc595_chain_driver #(
  parameter int CHIPS     = 2,
  parameter int CLK_DIV   = 2,
  parameter int MSB_FIRST = 1,
  parameter int REFRESH   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*CHIPS-1:0] data,
  input  logic               lock,
  output logic               busy,
  output logic               done,
  output logic               clk595,
  output logic               out595,
  output logic               lock595,
  output logic               oe595_n
);

  localparam int W  = 8 * CHIPS;
  localparam int BW = $clog2(W + 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int RW = (REFRESH > 0) ? $clog2(REFRESH + 1) : 1;
  localparam logic [BW-1:0] BITS_INIT = BW'(W);
  localparam logic [BW-1:0] BITS_LAST = BW'(1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [RW-1:0] REF_MAX   = RW'(REFRESH);
  localparam bit            MSB       = (MSB_FIRST != 0);

  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH, FINISH} state_t;

  state_t         r_state;
  state_t         w_stateNext;
  logic           r_lockQ;
  logic [W-1:0]   r_shadow;
  logic [W-1:0]   r_pend;
  logic           r_pendValid;
  logic [W-1:0]   r_shift;
  logic [BW-1:0]  r_bitCnt;
  logic [DW-1:0]  r_divCnt;
  logic [RW-1:0]  r_refCnt;
  logic           r_sent;
  logic           r_busy;
  logic           r_done;
  logic           r_clk595;
  logic           r_lock595;
  logic           r_oeN;

  logic           w_loadEdge;
  logic           w_phaseEnd;
  logic           w_refreshHit;
  logic           w_start;
  logic [W-1:0]   w_shiftNext;
  logic           w_busyNext;
  logic           w_doneNext;
  logic           w_clkNext;
  logic           w_latchNext;
  logic           w_oeNNext;

  assign w_loadEdge   = lock & ~r_lockQ;
  assign w_phaseEnd   = (r_divCnt == DIV_LAST);
  assign w_refreshHit = (REFRESH > 0) && r_sent && (r_refCnt == REF_MAX);
  assign w_start      = (r_state == IDLE) && (w_loadEdge || r_pendValid || w_refreshHit);
  assign w_shiftNext  = MSB ? {r_shift[W-2:0], 1'b0} : {1'b0, r_shift[W-1:1]};

  // State register; the pin-facing outputs are registered alongside it so they never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_clk595  <= 1'b0;
      r_lock595 <= 1'b0;
      r_oeN     <= 1'b1;
    end else begin
      r_state   <= w_stateNext;
      r_busy    <= w_busyNext;
      r_done    <= w_doneNext;
      r_clk595  <= w_clkNext;
      r_lock595 <= w_latchNext;
      r_oeN     <= w_oeNNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:     if (w_start) w_stateNext = SHIFT_LO;
      SHIFT_LO: if (w_phaseEnd) w_stateNext = SHIFT_HI;
      SHIFT_HI: if (w_phaseEnd) w_stateNext = (r_bitCnt == BITS_LAST) ? LATCH : SHIFT_LO;
      LATCH:    if (w_phaseEnd) w_stateNext = FINISH;
      FINISH:   w_stateNext = IDLE;
      default:  w_stateNext = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so the registered copies line up with it.
  always_comb begin
    w_busyNext  = (w_stateNext != IDLE);
    w_doneNext  = (r_state == FINISH);
    w_clkNext   = (w_stateNext == SHIFT_HI);
    w_latchNext = (w_stateNext == LATCH);
    w_oeNNext   = r_oeN & (w_stateNext != FINISH);
  end

  // Priority at frame start is load edge, then pending, then refresh of the shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lockQ     <= 1'b1;
      r_shadow    <= '0;
      r_pend      <= '0;
      r_pendValid <= 1'b0;
      r_shift     <= '0;
      r_bitCnt    <= '0;
      r_divCnt    <= '0;
      r_refCnt    <= '0;
      r_sent      <= 1'b0;
    end else begin
      r_lockQ <= lock;
      if (r_state == IDLE) begin
        if (w_start) begin
          r_bitCnt <= BITS_INIT;
          r_refCnt <= '0;
        end else if (r_refCnt != REF_MAX) begin
          r_refCnt <= r_refCnt + 1'b1;
        end
        if (w_loadEdge) begin
          r_shadow    <= data;
          r_shift     <= data;
          r_pendValid <= 1'b0;
        end else if (r_pendValid) begin
          r_shadow    <= r_pend;
          r_shift     <= r_pend;
          r_pendValid <= 1'b0;
        end else if (w_refreshHit) begin
          r_shift <= r_shadow;
        end
      end else if (w_loadEdge) begin
        r_pend      <= data;
        r_pendValid <= 1'b1;
      end
      if (r_state == SHIFT_HI && w_phaseEnd) begin
        r_bitCnt <= r_bitCnt - 1'b1;
        if (r_bitCnt != BITS_LAST) r_shift <= w_shiftNext;
      end
      if (r_state == FINISH) r_sent <= 1'b1;
      if (r_state == IDLE || w_stateNext != r_state) r_divCnt <= '0;
      else r_divCnt <= r_divCnt + 1'b1;
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign clk595  = r_clk595;
  assign lock595 = r_lock595;
  assign oe595_n = r_oeN;
  assign out595  = MSB ? r_shift[W-1] : r_shift[0];

endmodule

// File: doc/hc595_chain_driver.md
Name: hc595_chain_driver

Overview:
- Serial driver for a daisy-chain of CHIPS 74HC595 shift registers, CHIPS*8 bits total.
- Generalises the fixed 16-bit driver with:
  - a programmable shift-clock divider;
  - selectable bit order;
  - a one-deep pending buffer, so loads are not lost while busy;
  - optional periodic auto-refresh;
  - a managed output-enable.
- Sits between board logic (display or LED data) and the 595 pins.

Parameters:
- CHIPS, 2: number of chained 595s; W = 8*CHIPS.
- CLK_DIV, 2: system cycles per half shift-clock period; must be >= 1.
- MSB_FIRST, 1: 1 = data[W-1] shifted first; 0 = data[0] shifted first.
- REFRESH, 0: 0 = one-shot only; N > 0 = resend the last frame after N idle cycles.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- data  in  W  parallel frame, sampled on an accepted load.
- lock  in  1  load request, rising-edge sensitive.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse at frame completion.
- clk595  out  1  595 SRCLK.
- out595  out  1  595 SER.
- lock595  out  1  595 RCLK (latch).
- oe595_n  out  1  595 /OE.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: busy=0, done=0, clk595=0, out595=0, lock595=0, oe595_n=1. Shadow and pending registers are cleared. Refresh counter = 0. The lock edge-detect register is set to 1, so a lock held high across reset does not start a frame.
- Reset mid-frame: all outputs return to their reset values at the next edge. The frame is abandoned and nothing is latched.
- Load edge: lock=1 and lock_q=0 at a clock edge.
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH, FINISH.
- IDLE:
  - On a load edge, capture data into shadow, load the bit counter with W, go to SHIFT_LO. busy=1 from the next cycle.
  - Otherwise, if a pending frame exists, start it from the pending register, same as a load edge.
  - Otherwise, if REFRESH>0, at least one frame has been sent, and the refresh counter reaches REFRESH, restart from shadow.
  - Priority: load edge > pending > refresh.
- SHIFT_LO: held CLK_DIV cycles.
  - clk595=0; out595 = current bit, stable for the whole phase.
  - Then go to SHIFT_HI.
- SHIFT_HI: held CLK_DIV cycles.
  - clk595=1; out595 unchanged. The 595 shifts on the rising edge.
  - Decrement the bit counter; go to SHIFT_LO if bits remain, else go to LATCH.
- LATCH: held CLK_DIV cycles.
  - clk595=0, lock595=1, out595 holds the last bit.
  - Then go to FINISH.
- FINISH: one cycle.
  - lock595=0, busy still 1. oe595_n goes to 0 from here on, and stays 0 until reset.
  - Next cycle is IDLE with busy=0 and done=1 for exactly that cycle.
- busy duration per frame = (2W+1)*CLK_DIV + 1 cycles.
- Bit order:
  - MSB_FIRST=1: data[W-1] down to data[0].
  - MSB_FIRST=0: data[0] up to data[W-1].
- Load edge while busy:
  - data is captured into the pending register; the latest edge wins.
  - The current frame is not disturbed.
  - The pending frame starts in the done cycle, so busy is low for exactly one cycle between frames.
- Refresh counter:
  - Cleared on every frame start; increments each IDLE cycle; saturates at REFRESH.
  - busy rises REFRESH+1 cycles after the done pulse when no lock or pending intervenes.
- A load edge and a refresh expiry in the same cycle: the load edge wins, with new data.
- clk595 and lock595 are never 1 simultaneously. clk595 is glitch-free: a registered output.

Test Plan (CHIPS=2, CLK_DIV=2, W=16 unless stated):
1. Reset, then one lock pulse with data=16'hEAAB, MSB_FIRST=1.
   - out595 sampled at the 16 clk595 rising edges is 1110101010101011.
   - busy high exactly 67 cycles.
   - One lock595 pulse of 2 cycles after the 16th rise.
   - done pulses once; oe595_n 1->0 at FINISH.
2. Same data with MSB_FIRST=0: bit sequence is 1101010101010111; timing is identical to scenario 1.
3. Frame 16'h00FF running; at cycle 20 lock with 16'h1234, at cycle 30 lock with 16'hA5A5.
   - First frame completes unchanged.
   - busy low exactly 1 cycle, coincident with done.
   - Second frame shifts 16'hA5A5; 16'h1234 is never sent.
4. Assert rst at cycle 25 of a frame.
   - Next cycle: busy=0, clk595=0, lock595=0, oe595_n=1.
   - lock595 never pulsed.
   - A fresh lock afterwards sends the full frame correctly.
5. REFRESH=100: send 16'hC3C3 and hold lock low.
   - busy re-rises 101 cycles after each done, resending 16'hC3C3 indefinitely.
   - A lock edge in the expiry cycle sends the new data instead.
6. CHIPS=3, CLK_DIV=1: lock with 24'hF0F0F0.
   - 24 rises; busy high 50 cycles; lock held high through and after reset gives no spurious frame.
